// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared ALU opcodes and ALU arbiter state type
package riscv_pkg;

  localparam int XLEN = 32;

  // funct3 encodings for register/immediate ALU operations
  localparam logic [2:0] F3_ALU_ADD  = 3'b000;  // ADD, or SUB when alt is set
  localparam logic [2:0] F3_ALU_SLL  = 3'b001;
  localparam logic [2:0] F3_ALU_SLT  = 3'b010;
  localparam logic [2:0] F3_ALU_SLTU = 3'b011;
  localparam logic [2:0] F3_ALU_XOR  = 3'b100;
  localparam logic [2:0] F3_ALU_SRL  = 3'b101;  // SRL, or SRA when alt is set
  localparam logic [2:0] F3_ALU_OR   = 3'b110;
  localparam logic [2:0] F3_ALU_AND  = 3'b111;

  typedef enum logic {ARB_IDLE, ARB_HOLD} alu_arb_state_t;

  // Two-port one-hot select vector for a port index
  function automatic logic [1:0] port_onehot(input logic port);
    return port ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational RV32 integer ALU
module alu
  import riscv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic             alt,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic [WIDTH-1:0] result
);

  localparam int SHW = $clog2(WIDTH);

  logic [SHW-1:0] shamt;

  // Only the low bits of operand2 select the shift distance
  assign shamt = op2[SHW-1:0];

  // Evaluate the selected operation; alt picks SUB over ADD and SRA over SRL
  always_comb begin
    result = '0;
    case (op)
      F3_ALU_ADD:  result = alt ? (op1 - op2) : (op1 + op2);
      F3_ALU_SLL:  result = op1 << shamt;
      F3_ALU_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
      F3_ALU_SLTU: result = {{(WIDTH-1){1'b0}}, (op1 < op2)};
      F3_ALU_XOR:  result = op1 ^ op2;
      F3_ALU_SRL:  result = alt ? WIDTH'($signed(op1) >>> shamt) : (op1 >> shamt);
      F3_ALU_OR:   result = op1 | op2;
      F3_ALU_AND:  result = op1 & op2;
      default:     result = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-port arbiter sharing one ALU with a registered, handshaked result
module alu_arbiter
  import riscv_pkg::*;
#(
  parameter bit RR_EN = 1'b1,
  parameter int XLEN  = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [1:0]           req_valid_i,
  output logic [1:0]           req_ready_o,
  input  logic [1:0][2:0]      req_op_i,
  input  logic [1:0]           req_alt_i,
  input  logic [1:0][XLEN-1:0] req_op1_i,
  input  logic [1:0][XLEN-1:0] req_op2_i,
  output logic [1:0]           rsp_valid_o,
  input  logic [1:0]           rsp_ready_i,
  output logic [XLEN-1:0]      rsp_result_o
);

  alu_arb_state_t  state;
  logic            held_port;
  logic            rr_last;

  logic            can_accept;
  logic            gnt_port;
  logic            xfer;
  logic            alu_sel;
  logic [XLEN-1:0] alu_y;

  // Grant decision: a slot is free when idle or when the current owner drains this cycle
  always_comb begin
    can_accept = (state == ARB_IDLE) || ((state == ARB_HOLD) && rsp_ready_i[held_port]);
    if (RR_EN && (&req_valid_i)) begin
      gnt_port = ~rr_last;
    end else begin
      // single valid requester wins; in fixed mode port 0 wins whenever valid
      gnt_port = ~req_valid_i[0];
    end
    xfer        = !rst_i && can_accept && (|req_valid_i);
    req_ready_o = xfer ? port_onehot(gnt_port) : 2'b00;
    // port 0 drives the ALU whenever nothing is transferring
    alu_sel     = xfer && gnt_port;
  end

  alu #(.WIDTH(XLEN)) u_alu (
    .op     (req_op_i[alu_sel]),
    .alt    (req_alt_i[alu_sel]),
    .op1    (req_op1_i[alu_sel]),
    .op2    (req_op2_i[alu_sel]),
    .result (alu_y)
  );

  // Result ownership follows the held state directly
  assign rsp_valid_o = (state == ARB_HOLD) ? port_onehot(held_port) : 2'b00;

  // Capture result and owner on transfer; release when the owner consumes with nothing new
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= ARB_IDLE;
      held_port    <= 1'b0;
      rr_last      <= 1'b1;
      rsp_result_o <= '0;
    end else if (xfer) begin
      state        <= ARB_HOLD;
      held_port    <= gnt_port;
      rr_last      <= gnt_port;
      rsp_result_o <= alu_y;
    end else if ((state == ARB_HOLD) && rsp_ready_i[held_port]) begin
      state        <= ARB_IDLE;
    end
  end

endmodule
